// File: rtl/arm_bus_slave_pkg.sv
// Shared definitions for the asynchronous-bus register slave: register map indices and FSM encoding.
package arm_bus_slave_pkg;

  localparam int REG_ID       = 0;
  localparam int REG_IRQ_STAT = 1;
  localparam int REG_IRQ_MASK = 2;
  localparam int REG_GP0      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/bus_sync.sv
// Multi-stage flop synchronizer for a bundle of asynchronous bus inputs.
// Each bit resets to its own value so strobes come out of reset inactive.
module bus_sync #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= RST_VAL;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/arm_bus_slave.sv
// Register slave on an asynchronous strobe bus: synchronized inputs, 4-state access FSM,
// ID/IRQ-status/IRQ-mask/general registers, fixed SYNC_STAGES+2 acknowledge latency.
module arm_bus_slave
  import arm_bus_slave_pkg::*;
#(
  parameter int          DW          = 32,
  parameter int          AW          = 24,
  parameter int          NREGS       = 16,
  parameter int          NIRQ        = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] ID_VALUE    = 32'h0453_0002
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         addr,
  input  logic [DW-1:0]         din,
  input  logic [DW/8-1:0]       be_n,
  input  logic                  rs_n,
  input  logic                  ws_n,
  input  logic                  as,
  input  logic [NIRQ-1:0]       irq_src,
  output logic [DW-1:0]         dout,
  output logic                  dout_en,
  output logic                  dtack_n,
  output logic                  irq,
  output logic [NREGS*DW-1:0]   regs_q
);

  localparam int BW = DW / 8;
  localparam int IW = $clog2(NREGS);
  localparam int SW = AW + DW + BW + 3;
  localparam logic [SW-1:0] SYNC_RST = {1'b0, 1'b1, 1'b1, {BW{1'b1}}, {DW{1'b0}}, {AW{1'b0}}};

  logic [SW-1:0] sync_q;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] din_s;
  logic [BW-1:0] be_s;
  logic          rs_s, ws_s, as_s;

  bus_sync #(.W(SW), .DEPTH(SYNC_STAGES), .RST_VAL(SYNC_RST)) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     ({as, ws_n, rs_n, be_n, din, addr}),
    .q     (sync_q)
  );

  assign {as_s, ws_s, rs_s, be_s, din_s, addr_s} = sync_q;

  state_t state, state_nxt;
  logic   wr_en, rd_en, ack_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Write is tested first so it wins when both strobes are low.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (as_s && !ws_s)      state_nxt = ST_WRITE;
        else if (as_s && !rs_s) state_nxt = ST_READ;
      end
      ST_WRITE, ST_READ: state_nxt = ST_ACK;
      ST_ACK:  if (rs_s && ws_s) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en    = (state == ST_WRITE);
    rd_en    = (state == ST_READ);
    dtack_n  = (state != ST_ACK);
    ack_done = (state == ST_ACK) && rs_s && ws_s;
  end

  logic [IW-1:0] idx;
  logic          oor, wr_hit, unused_ok;
  logic [DW-1:0] bm;
  logic [DW-1:0] rd_data;
  logic [NIRQ-1:0] w1c;

  assign idx       = addr_s[IW+1:2];
  assign oor       = |(addr_s >> (IW + 2));
  assign wr_hit    = wr_en && !oor;
  assign unused_ok = ^addr_s[1:0];

  always_comb begin
    bm = '0;
    for (int l = 0; l < BW; l++) bm[8*l +: 8] = {8{~be_s[l]}};
  end

  assign w1c = (wr_hit && idx == IW'(REG_IRQ_STAT)) ? (din_s[NIRQ-1:0] & bm[NIRQ-1:0]) : '0;

  logic [NIRQ-1:0] status, mask;
  logic [DW-1:0]   gp [REG_GP0:NREGS-1];

  // A new event outranks a same-cycle W1C of the same bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status <= '0;
      mask   <= '0;
      irq    <= 1'b0;
    end else begin
      status <= (status & ~w1c) | irq_src;
      if (wr_hit && idx == IW'(REG_IRQ_MASK))
        mask <= (mask & ~bm[NIRQ-1:0]) | (din_s[NIRQ-1:0] & bm[NIRQ-1:0]);
      irq <= |(status & mask);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = REG_GP0; g < NREGS; g++) gp[g] <= '0;
    end else if (wr_hit) begin
      for (int g = REG_GP0; g < NREGS; g++)
        if (idx == IW'(g)) gp[g] <= (gp[g] & ~bm) | (din_s & bm);
    end
  end

  logic [DW-1:0] reg_file [NREGS];

  for (genvar g = 0; g < NREGS; g++) begin : g_map
    if (g == REG_ID) begin : g_id
      assign reg_file[g] = DW'(ID_VALUE);
    end else if (g == REG_IRQ_STAT) begin : g_stat
      assign reg_file[g] = DW'(status);
    end else if (g == REG_IRQ_MASK) begin : g_mask
      assign reg_file[g] = DW'(mask);
    end else begin : g_gp
      assign reg_file[g] = gp[g];
    end
    assign regs_q[g*DW +: DW] = reg_file[g];
  end

  assign rd_data = oor ? '0 : reg_file[idx];

  // dout is held between reads; only dout_en decides whether it reaches the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout    <= '0;
      dout_en <= 1'b0;
    end else begin
      if (rd_en) begin
        dout    <= rd_data;
        dout_en <= 1'b1;
      end else if (ack_done) begin
        dout_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arm_bus_slave.sv
// Self-checking bench for arm_bus_slave: directed register-map scenarios plus random accesses
// compared against a byte-level behavioural model of the register file.
module tb_arm_bus_slave;

  localparam int S = 2;
  localparam logic [31:0] ID = 32'h0453_0002;

  logic         clk = 1'b0;
  logic         rst;
  logic [23:0]  addr;
  logic [31:0]  din;
  logic [3:0]   be_n;
  logic         rs_n, ws_n, as;
  logic [7:0]   irq_src;
  logic [31:0]  dout;
  logic         dout_en, dtack_n, irq;
  logic [511:0] regs_q;

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] m_gp [16];
  logic [7:0]  m_stat, m_mask;
  logic [31:0] last_dout;

  always #5 clk = ~clk;

  arm_bus_slave #(.DW(32), .AW(24), .NREGS(16), .NIRQ(8), .SYNC_STAGES(S), .ID_VALUE(ID)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .be_n(be_n), .rs_n(rs_n), .ws_n(ws_n),
    .as(as), .irq_src(irq_src), .dout(dout), .dout_en(dout_en), .dtack_n(dtack_n),
    .irq(irq), .regs_q(regs_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [23:0] a);
    int i;
    i = int'(a[5:2]);
    if (a[23:6] != 18'd0) return 32'd0;
    case (i)
      0:       return ID;
      1:       return {24'd0, m_stat};
      2:       return {24'd0, m_mask};
      default: return m_gp[i];
    endcase
  endfunction

  task automatic model_write(input logic [23:0] a, input logic [31:0] d, input logic [3:0] be);
    int i;
    i = int'(a[5:2]);
    if (a[23:6] != 18'd0) return;
    if (i == 1 && !be[0]) m_stat = m_stat & ~d[7:0];
    else if (i == 2 && !be[0]) m_mask = d[7:0];
    else if (i >= 3)
      for (int l = 0; l < 4; l++) if (!be[l]) m_gp[i][8*l +: 8] = d[8*l +: 8];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_gp[i] = 32'd0;
    m_stat = 8'd0;
    m_mask = 8'd0;
    last_dout = 32'd0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s regs_q[%0d]", tag, i), regs_q[i*32 +: 32], model_read(24'(i * 4)));
  endtask

  task automatic release_bus(input string tag);
    int n;
    as = 1'b0; rs_n = 1'b1; ws_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (dtack_n !== 1'b1 && n < 20);
    check({tag, " dtack_release"}, {31'd0, dtack_n}, 32'd1);
    check({tag, " dout_en_release"}, {31'd0, dout_en}, 32'd0);
    check({tag, " dout_hold"}, dout, last_dout);
    @(posedge clk); #1;
  endtask

  // pulse raises irq_src[0] for exactly the cycle in which a write commits.
  task automatic access(input string tag, input bit wr, input bit rd, input logic [23:0] a,
                        input logic [31:0] d, input logic [3:0] be, input bit pulse);
    int n;
    logic [31:0] exp_rd;
    bit is_read;
    is_read = rd && !wr;
    exp_rd = model_read(a);
    @(posedge clk); #1;
    addr = a; din = d; be_n = be; as = 1'b1; ws_n = ~wr; rs_n = ~rd;
    n = 0;
    do begin
      @(posedge clk); n++; #1;
      if (pulse) irq_src = (n == S + 1) ? 8'h01 : 8'h00;
    end while (dtack_n !== 1'b0 && n < 20);
    irq_src = 8'h00;
    check({tag, " latency"}, 32'(n), 32'(S + 2));
    check({tag, " dout_en"}, {31'd0, dout_en}, {31'd0, is_read});
    if (is_read) begin
      check({tag, " dout"}, dout, exp_rd);
      last_dout = exp_rd;
    end
    if (wr) model_write(a, d, be);
    if (pulse) m_stat = m_stat | 8'h01;
    release_bus(tag);
    check({tag, " irq"}, {31'd0, irq}, {31'd0, |(m_stat & m_mask)});
  endtask

  initial begin
    int n;
    logic [23:0] ra;
    logic [3:0]  rbe;
    logic [31:0] rd;
    int op;

    rst = 1'b0; addr = '0; din = '0; be_n = 4'hF; rs_n = 1'b1; ws_n = 1'b1; as = 1'b0;
    irq_src = 8'h00;
    model_reset();
    #12;
    check("rst dtack_n", {31'd0, dtack_n}, 32'd1);
    check("rst dout_en", {31'd0, dout_en}, 32'd0);
    check("rst dout", dout, 32'd0);
    check("rst irq", {31'd0, irq}, 32'd0);
    check_regs("rst");
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);

    access("wr_deadbeef", 1, 0, 24'h00000C, 32'hDEADBEEF, 4'b0000, 0);
    access("rd_deadbeef", 0, 1, 24'h00000C, 32'h0, 4'b0000, 0);
    access("wr_be1010", 1, 0, 24'h00000C, 32'h11223344, 4'b1010, 0);
    access("rd_be1010", 0, 1, 24'h00000C, 32'h0, 4'b0000, 0);
    check("be1010 value", last_dout, 32'hDE22BE44);
    access("wr_id", 1, 0, 24'h000000, 32'hFFFFFFFF, 4'b0000, 0);
    access("rd_id", 0, 1, 24'h000000, 32'h0, 4'b0000, 0);
    check("id value", last_dout, 32'h04530002);
    access("rd_oor", 0, 1, 24'h001000, 32'h0, 4'b0000, 0);
    access("wr_oor", 1, 0, 24'h001010, 32'hA5A5A5A5, 4'b0000, 0);
    access("both_strobes", 1, 1, 24'h000010, 32'h00000005, 4'b0000, 0);
    access("rd_reg4", 0, 1, 24'h000010, 32'h0, 4'b0000, 0);
    check("reg4 value", last_dout, 32'h00000005);

    access("wr_mask", 1, 0, 24'h000008, 32'h00000001, 4'b0000, 0);
    check("irq idle", {31'd0, irq}, 32'd0);
    @(posedge clk); #1; irq_src = 8'h01;
    @(posedge clk); #1; irq_src = 8'h00;
    m_stat = m_stat | 8'h01;
    @(posedge clk); #1;
    check("irq after pulse", {31'd0, irq}, 32'd1);
    access("w1c_with_pulse", 1, 0, 24'h000004, 32'h00000001, 4'b0000, 1);
    access("rd_stat_kept", 0, 1, 24'h000004, 32'h0, 4'b0000, 0);
    check("stat kept", last_dout, 32'h00000001);
    access("w1c_alone", 1, 0, 24'h000004, 32'h00000001, 4'b0000, 0);
    access("rd_stat_clr", 0, 1, 24'h000004, 32'h0, 4'b0000, 0);
    check("irq cleared", {31'd0, irq}, 32'd0);
    access("wr_mask_hi", 1, 0, 24'h000008, 32'hFFFFFFFF, 4'b0000, 0);
    access("rd_mask_hi", 0, 1, 24'h000008, 32'h0, 4'b0000, 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3) == 0) ra = 24'($urandom);
      else ra = {18'd0, 4'($urandom_range(15)), 2'($urandom_range(3))};
      rbe = 4'($urandom_range(15));
      rd  = $urandom;
      op  = int'($urandom_range(2));
      if (op == 0) access($sformatf("rnd%0d_wr", k), 1, 0, ra, rd, rbe, 0);
      else access($sformatf("rnd%0d_rd", k), 0, 1, ra, rd, rbe, 0);
    end
    check_regs("random");

    // Reset while a write sits in ACK, keep the strobe low across release.
    access("pre_rst_wr", 1, 0, 24'h000018, 32'h0BADF00D, 4'b0000, 0);
    @(posedge clk); #1;
    addr = 24'h000014; din = 32'hCAFE0001; be_n = 4'b0000; as = 1'b1; ws_n = 1'b0;
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (dtack_n !== 1'b0 && n < 20);
    check("pre_rst latency", 32'(n), 32'(S + 2));
    rst = 1'b0;
    model_reset();
    #1;
    check("mid_rst dtack_n", {31'd0, dtack_n}, 32'd1);
    check("mid_rst dout_en", {31'd0, dout_en}, 32'd0);
    check("mid_rst dout", dout, 32'd0);
    check("mid_rst irq", {31'd0, irq}, 32'd0);
    check_regs("mid_rst");
    @(posedge clk); #1;
    din = 32'h12345678;
    rst = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (dtack_n !== 1'b0 && n < 20);
    check("post_rst latency", 32'(n), 32'(S + 2));
    model_write(24'h000014, 32'h12345678, 4'b0000);
    release_bus("post_rst");
    access("rd_post_rst", 0, 1, 24'h000014, 32'h0, 4'b0000, 0);
    check_regs("final");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
